// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned IMEM_SIZE  = 1024;
  localparam int unsigned IMEM_AW    = $clog2(IMEM_SIZE);
  localparam int unsigned ADDR_SHIFT = 2;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef logic [XLEN-1:0] inst_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    inst_t           inst;
    logic            filled;
  } fetch_entry_t;

  // Instruction addresses are always word aligned
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time, filled by
// responses in request order and popped by decode.
module fetch_queue
  import if_stage_pkg::*;
#(
  parameter int unsigned QDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     alloc_en,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     fill_en,
  input  inst_t                    fill_inst,
  input  logic                     pop_en,
  output fetch_entry_t             head_c,
  output logic [$clog2(QDEPTH):0]  free_cnt_c,
  output logic [$clog2(QDEPTH):0]  unfilled_cnt_c
);

  localparam int unsigned IW = $clog2(QDEPTH);
  localparam int unsigned PW = IW + 1;

  fetch_entry_t  entries [QDEPTH];
  logic [PW-1:0] alloc_ptr;
  logic [PW-1:0] fill_ptr;
  logic [PW-1:0] head_ptr;

  // Pointers carry one wrap bit so full and empty are distinguishable
  assign head_c         = entries[head_ptr[IW-1:0]];
  assign free_cnt_c     = PW'(QDEPTH) - (alloc_ptr - head_ptr);
  assign unfilled_cnt_c = alloc_ptr - fill_ptr;

  // Entry storage and pointer updates; flush drops everything outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        entries[IW'(i)] <= '0;
      end
    end else if (flush) begin
      alloc_ptr <= '0;
      fill_ptr  <= '0;
      head_ptr  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        entries[IW'(i)].filled <= 1'b0;
      end
    end else begin
      if (alloc_en) begin
        entries[alloc_ptr[IW-1:0]].pc     <= alloc_pc;
        entries[alloc_ptr[IW-1:0]].filled <= 1'b0;
        alloc_ptr                         <= alloc_ptr + PW'(1);
      end
      if (fill_en) begin
        entries[fill_ptr[IW-1:0]].inst   <= fill_inst;
        entries[fill_ptr[IW-1:0]].filled <= 1'b1;
        fill_ptr                         <= fill_ptr + PW'(1);
      end
      if (pop_en) begin
        entries[head_ptr[IW-1:0]].filled <= 1'b0;
        head_ptr                         <= head_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues in-order IMEM reads, buffers the
// returned words and hands them to decode; redirects flush and discard.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [XLEN-1:0]    imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output inst_t              id_inst,
  output logic [XLEN-1:0]    id_pc
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned DW = $clog2(QDEPTH) + 2;

  logic [XLEN-1:0] pc;
  logic [DW-1:0]   discard_cnt;
  logic            fetch_en;
  fetch_entry_t    head;
  logic [CW-1:0]   free_cnt;
  logic [CW-1:0]   unfilled_cnt;
  logic            req_fire;
  logic            rsp_keep;
  logic            id_fire;

  // Handshake qualification; a redirect suppresses every transfer that cycle
  assign imem_req_valid = fetch_en & (free_cnt != '0) & ~redirect_valid;
  assign imem_addr      = IMEM_AW'(pc >> ADDR_SHIFT);
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_keep       = imem_rsp_valid & ~redirect_valid & (discard_cnt == '0);
  assign id_valid       = head.filled & ~redirect_valid;
  assign id_fire        = id_valid & id_ready;
  assign id_inst        = head.inst;
  assign id_pc          = head.pc;

  fetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (redirect_valid),
    .alloc_en       (req_fire),
    .alloc_pc       (pc),
    .fill_en        (rsp_keep),
    .fill_inst      (imem_rsp_data),
    .pop_en         (id_fire),
    .head_c         (head),
    .free_cnt_c     (free_cnt),
    .unfilled_cnt_c (unfilled_cnt)
  );

  // Fetch starts the cycle after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_en <= 1'b0;
    else        fetch_en <= 1'b1;
  end

  // PC: redirect wins, otherwise advance on each accepted request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pc <= RESET_PC;
    else if (redirect_valid) pc <= align_pc(redirect_pc);
    else if (req_fire)       pc <= pc + XLEN'(4);
  end

  // Count responses still owed to requests abandoned by a redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      discard_cnt <= discard_cnt + DW'(unfilled_cnt) - DW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (discard_cnt != '0)) begin
      discard_cnt <= discard_cnt - DW'(1);
    end
  end

  // A kept response must land in an allocated, unfilled entry
  a_rsp_has_slot : assert property (@(posedge clk) disable iff (!rst_n)
    rsp_keep |-> (unfilled_cnt != '0))
    else $error("if_stage: IMEM response with no outstanding request");

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected PCs are queued by the stimulus,
// a monitor pops and compares on every decode handshake.
module tb_if_stage;
  import if_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // main DUT (RESET_PC = 0)
  logic              rst_n, imem_req_valid, imem_req_ready;
  logic [IMEM_AW-1:0] imem_addr;
  logic              imem_rsp_valid = 1'b0;
  logic [XLEN-1:0]   imem_rsp_data  = '0;
  logic              redirect_valid, id_valid, id_ready;
  logic [XLEN-1:0]   redirect_pc, id_pc;
  inst_t             id_inst;

  // second DUT (RESET_PC near the top of the address space)
  logic              b_rst_n, b_req_valid, b_req_ready;
  logic [IMEM_AW-1:0] b_addr;
  logic              b_rsp_valid = 1'b0;
  logic [XLEN-1:0]   b_rsp_data  = '0;
  logic              b_redirect_valid, b_id_valid;
  logic              b_id_ready = 1'b1;
  logic [XLEN-1:0]   b_redirect_pc, b_id_pc;
  inst_t             b_id_inst;

  if_stage #(.QDEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  if_stage #(.QDEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_addr(b_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .id_valid(b_id_valid), .id_ready(b_id_ready), .id_inst(b_id_inst), .id_pc(b_id_pc)
  );

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  typedef struct { logic [9:0] addr; int unsigned due; } pend_t;

  // ---------------- IMEM model, main DUT (programmable latency) -----------
  int unsigned lat = 1;
  logic        acc_s = 1'b0;
  logic [9:0]  acc_addr = '0;
  int unsigned acc_cnt = 0;
  pend_t       pend[$];

  always @(negedge clk) begin
    acc_s    = imem_req_valid & imem_req_ready;
    acc_addr = imem_addr;
    if (acc_s) acc_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
    end else begin
      if (acc_s) pend.push_back('{acc_addr, cyc - 1 + lat});
      imem_rsp_valid = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end
    end
  end

  // ---------------- IMEM model, second DUT (1-cycle latency) --------------
  logic       b_acc_s = 1'b0;
  logic [9:0] b_acc_addr = '0;
  always @(negedge clk) begin
    b_acc_s    = b_req_valid & b_req_ready;
    b_acc_addr = b_addr;
  end

  always @(posedge clk) begin
    #1;
    b_rsp_valid = b_rst_n & b_acc_s;
    if (b_rst_n && b_acc_s) b_rsp_data = mem_word(b_acc_addr);
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] b_exp_q[$];
  int unsigned hs_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && id_valid && id_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_issue: got pc %0h, expected none", id_pc);
        end else begin
          e = exp_q.pop_front();
          check("id_pc_inst", {id_pc, id_inst}, {e, mem_word(e[11:2])});
        end
      end
      if (b_rst_n && b_id_valid && b_id_ready) begin
        if (b_exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected_issue: got pc %0h, expected none", b_id_pc);
        end else begin
          e = b_exp_q.pop_front();
          check("b_id_pc_inst", {b_id_pc, b_id_inst}, {e, mem_word(e[11:2])});
        end
      end
    end
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || b_exp_q.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size() + b_exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned a0;
    int unsigned acc0;
    rst_n = 1'b0; b_rst_n = 1'b0;
    imem_req_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    b_req_ready = 1'b0; b_redirect_valid = 1'b0; b_redirect_pc = '0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_id_valid",  64'(id_valid), 64'd0);
    check("rst_id_pc",     64'(id_pc), 64'd0);
    check("rst_id_inst",   64'(id_inst), 64'd0);
    @(posedge clk); #1; rst_n = 1'b1; b_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
    check("post_rst_addr", 64'(imem_addr), 64'd0);
    check("b_reset_addr", 64'(b_addr), 64'h3FE);

    // 1: straight-line fetch, 1-cycle IMEM
    @(posedge clk); #1;
    id_ready = 1'b1; hs_cyc.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    imem_req_ready = 1'b1; a0 = cyc;
    repeat (3) @(posedge clk); #1; imem_req_ready = 1'b0;
    drain(20);
    check("t1_issue_count", 64'(hs_cyc.size()), 64'd3);
    if (hs_cyc.size() >= 3) begin
      check("t1_first_latency", 64'(hs_cyc[0] - a0), 64'd2);
      check("t1_back_to_back_1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
      check("t1_back_to_back_2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd1);
    end

    // 2: decode stalled -> queue fills to 4, output held
    @(posedge clk); #1;
    id_ready = 1'b0; acc0 = acc_cnt;
    exp_q.push_back(32'hC); exp_q.push_back(32'h10);
    exp_q.push_back(32'h14); exp_q.push_back(32'h18);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) begin
        check("t2_hold_valid", 64'(id_valid), 64'd1);
        check("t2_hold_pc", 64'(id_pc), 64'hC);
      end
      if (i == 9) begin
        check("t2_hold_pc_late", 64'(id_pc), 64'hC);
        check("t2_hold_inst_late", 64'(id_inst), 64'(mem_word(10'h3)));
        check("t2_full_no_req", 64'(imem_req_valid), 64'd0);
      end
    end
    @(posedge clk); #1;
    check("t2_accept_count", 64'(acc_cnt - acc0), 64'd4);
    imem_req_ready = 1'b0; id_ready = 1'b1;
    drain(20);

    // 3: 3-cycle IMEM, redirect with 3 reads in flight
    @(posedge clk); #1;
    lat = 3; imem_req_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check("t3_redirect_no_req", 64'(imem_req_valid), 64'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    exp_q.push_back(32'h100); exp_q.push_back(32'h104);
    @(negedge clk);
    check("t3_new_addr", 64'(imem_addr), 64'h40);
    @(posedge clk);
    @(posedge clk); #1; imem_req_ready = 1'b0;
    drain(30);

    // 4: redirect collides with an arriving response and a ready head
    @(posedge clk); #1;
    lat = 1; imem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    check("t4_id_valid_killed", 64'(id_valid), 64'd0);
    check("t4_head_pc", 64'(id_pc), 64'h108);
    @(posedge clk); #1;
    redirect_valid = 1'b0; imem_req_ready = 1'b1; exp_q.push_back(32'h200);
    @(posedge clk); #1; imem_req_ready = 1'b0;
    drain(20);

    // 5: PC wrap at the top of memory, misaligned redirect target
    @(posedge clk); #1;
    b_exp_q.push_back(32'hFFFF_FFF8); b_exp_q.push_back(32'hFFFF_FFFC); b_exp_q.push_back(32'h0);
    b_req_ready = 1'b1;
    repeat (3) @(posedge clk); #1; b_req_ready = 1'b0;
    drain(20);
    @(posedge clk); #1; b_redirect_valid = 1'b1; b_redirect_pc = 32'h103;
    @(posedge clk); #1; b_redirect_valid = 1'b0; b_req_ready = 1'b1; b_exp_q.push_back(32'h100);
    @(negedge clk);
    check("t5_aligned_addr", 64'(b_addr), 64'h40);
    @(posedge clk); #1; b_req_ready = 1'b0;
    drain(20);

    // 6: asynchronous reset with the queue half full
    @(posedge clk); #1;
    id_ready = 1'b0; imem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; imem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t6_prefill_valid", 64'(id_valid), 64'd1);
    check("t6_prefill_pc", 64'(id_pc), 64'h204);
    #2; rst_n = 1'b0; #1;
    check("t6_rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("t6_rst_id_valid", 64'(id_valid), 64'd0);
    check("t6_rst_id_pc", 64'(id_pc), 64'd0);
    check("t6_rst_id_inst", 64'(id_inst), 64'd0);
    check("t6_rst_addr", 64'(imem_addr), 64'd0);
    @(posedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    id_ready = 1'b1; exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    repeat (2) @(posedge clk); #1; imem_req_ready = 1'b1;
    repeat (2) @(posedge clk); #1; imem_req_ready = 1'b0;
    drain(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
